// File: rtl/conv_window_mac.sv
// conv_window_mac: multi-lane fixed-point MAC for one DxFxF convolution window.
// Accumulates image*filter over STEPS cycles, adds bias, rounds half up,
// saturates to DATA_WIDTH and optionally applies ReLU. Start / valid-ready handshake.
module conv_window_mac #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned D          = 1,
    parameter int unsigned F          = 5,
    parameter int unsigned LANES      = 1,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [D*F*F*DATA_WIDTH-1:0]   image,
    input  logic [D*F*F*DATA_WIDTH-1:0]   filter,
    input  logic [DATA_WIDTH-1:0]         bias,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         result,
    output logic                          sat
);

    localparam int unsigned N      = D * F * F;
    localparam int unsigned VEC_W  = N * DATA_WIDTH;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned IDX_W  = $clog2(N + LANES + 1);
    localparam int unsigned T_W    = ACC_WIDTH + 2;
    localparam int unsigned SHIFT  = LANES * DATA_WIDTH;

    // Round-half-up constant; zero when there are no fractional bits.
    localparam logic signed [T_W-1:0] RND = T_W'((1 << FRAC_BITS) >> 1);
    localparam logic signed [T_W-1:0] SAT_MAX =
        {{(T_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [T_W-1:0] SAT_MIN =
        {{(T_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                        state_q;
    state_t                        state_next;

    // Operand windows shift down by LANES elements per RUN cycle, filling with
    // zeros, so lanes past element N-1 always multiply zeros.
    logic [VEC_W-1:0]              img_q;
    logic [VEC_W-1:0]              flt_q;
    logic signed [DATA_WIDTH-1:0]  bias_q;
    logic                          relu_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [IDX_W-1:0]              idx_q;

    logic                          load_c;
    logic                          last_step_c;
    logic [IDX_W-1:0]              idx_step_c;
    logic signed [ACC_WIDTH-1:0]   lane_sum_c;
    logic signed [T_W-1:0]         t_sum_c;
    logic signed [T_W-1:0]         t_shr_c;
    logic [DATA_WIDTH-1:0]         res_c;
    logic                          sat_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Step bookkeeping: the step that moves idx to or past N is the last one.
    always_comb begin
        idx_step_c  = idx_q + IDX_W'(LANES);
        last_step_c = (idx_step_c >= IDX_W'(N));
    end

    // Next-state logic and job acceptance (IDLE, or the OUT handshake cycle).
    always_comb begin
        state_next = state_q;
        load_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load_c     = 1'b1;
                end
            end
            RUN: begin
                if (last_step_c) begin
                    state_next = POST;
                end
            end
            POST: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (start) begin
                        state_next = RUN;
                        load_c     = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sum of the LANES full-width signed products at the bottom of the window.
    always_comb begin
        lane_sum_c = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_c = lane_sum_c + ACC_WIDTH'(
                PROD_W'($signed(img_q[l*DATA_WIDTH +: DATA_WIDTH])) *
                PROD_W'($signed(flt_q[l*DATA_WIDTH +: DATA_WIDTH])));
        end
    end

    // Post-processing: bias, round half up, rescale, saturate, optional ReLU.
    always_comb begin
        t_sum_c = T_W'(acc_q) + (T_W'(bias_q) <<< FRAC_BITS) + RND;
        t_shr_c = t_sum_c >>> FRAC_BITS;
        sat_c   = 1'b0;
        res_c   = t_shr_c[DATA_WIDTH-1:0];
        if (t_shr_c > SAT_MAX) begin
            res_c = RES_MAX;
            sat_c = 1'b1;
        end else if (t_shr_c < SAT_MIN) begin
            res_c = RES_MIN;
            sat_c = 1'b1;
        end
        if (relu_q && t_shr_c[T_W-1]) begin
            res_c = '0;
        end
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            img_q     <= '0;
            flt_q     <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            acc_q     <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == OUT);
            if (load_c) begin
                img_q  <= image;
                flt_q  <= filter;
                bias_q <= bias;
                relu_q <= relu_en;
                acc_q  <= '0;
                idx_q  <= '0;
            end else if (state_q == RUN) begin
                acc_q <= acc_q + lane_sum_c;
                idx_q <= idx_step_c;
                img_q <= img_q >> SHIFT;
                flt_q <= flt_q >> SHIFT;
            end
            if (state_q == POST) begin
                result <= res_c;
                sat    <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Testbench for conv_window_mac: two instances (LANES=1 and LANES=4, 3x3 window),
// directed jobs, integer reference model and a per-cycle output compare process.
module tb_conv_window_mac;

    localparam int unsigned DW = 16;
    localparam int unsigned NE = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic signed [DW-1:0]  img_a [NE];
    logic signed [DW-1:0]  flt_a [NE];
    logic [DW-1:0]         bias_v;
    logic                  relu_v;
    logic [NE*DW-1:0]      image_v;
    logic [NE*DW-1:0]      filter_v;

    logic                  start_s [2];
    logic                  ready_s [2];
    logic                  busy_s  [2];
    logic                  valid_s [2];
    logic                  sat_s   [2];
    logic [DW-1:0]         res_s   [2];

    logic [DW-1:0]         exp_res [2];
    logic                  exp_sat [2];
    bit                    pending [2];

    int errors = 0;
    int checks = 0;

    always_comb begin
        for (int i = 0; i < NE; i++) begin
            image_v[i*DW +: DW]  = img_a[i];
            filter_v[i*DW +: DW] = flt_a[i];
        end
    end

    conv_window_mac #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .D(1), .F(3), .LANES(1), .ACC_WIDTH(40)
    ) u_l1 (
        .clk(clk), .reset(reset), .start(start_s[0]), .image(image_v),
        .filter(filter_v), .bias(bias_v), .relu_en(relu_v), .busy(busy_s[0]),
        .out_valid(valid_s[0]), .out_ready(ready_s[0]), .result(res_s[0]), .sat(sat_s[0])
    );

    conv_window_mac #(
        .DATA_WIDTH(16), .FRAC_BITS(8), .D(1), .F(3), .LANES(4), .ACC_WIDTH(40)
    ) u_l4 (
        .clk(clk), .reset(reset), .start(start_s[1]), .image(image_v),
        .filter(filter_v), .bias(bias_v), .relu_en(relu_v), .busy(busy_s[1]),
        .out_valid(valid_s[1]), .out_ready(ready_s[1]), .result(res_s[1]), .sat(sat_s[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer dot product, bias, round half up, clamp, ReLU.
    function automatic void model(output logic [DW-1:0] r, output logic s);
        longint t;
        t = 0;
        for (int i = 0; i < NE; i++) begin
            t += longint'(img_a[i]) * longint'(flt_a[i]);
        end
        t += longint'($signed(bias_v)) * 256;
        t += 128;
        t = t >>> 8;
        s = 1'b0;
        if (t > 32767) begin
            t = 32767;
            s = 1'b1;
        end else if (t < -32768) begin
            t = -32768;
            s = 1'b1;
        end
        if (relu_v && t < 0) t = 0;
        r = DW'(t);
    endfunction

    task automatic set_all(input logic [DW-1:0] iv, input logic [DW-1:0] fv,
                           input logic [DW-1:0] bv, input logic rv);
        for (int i = 0; i < NE; i++) begin
            img_a[i] = iv;
            flt_a[i] = fv;
        end
        bias_v = bv;
        relu_v = rv;
    endtask

    // Garbage on the inputs once a job is captured.
    task automatic scramble();
        set_all(16'h5A5A, 16'hA5C3, 16'h7777, ~relu_v);
    endtask

    task automatic wait_valid(input int k, output int cyc);
        cyc = 0;
        while (!valid_s[k] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic ack(input int k, input string nm);
        ready_s[k] = 1'b1;
        @(posedge clk); #1;
        ready_s[k] = 1'b0;
        pending[k] = 1'b0;
        check({nm, "_valid_drop"}, 32'(valid_s[k]), 32'd0);
        check({nm, "_busy_drop"}, 32'(busy_s[k]), 32'd0);
    endtask

    task automatic run_job(input int k, input int steps, input bit lit_en,
                           input logic [DW-1:0] lr, input logic ls,
                           input bit do_ack, input string nm);
        int cyc;
        logic [DW-1:0] r;
        logic s;
        model(r, s);
        exp_res[k] = r;
        exp_sat[k] = s;
        pending[k] = 1'b1;
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        scramble();
        check({nm, "_busy"}, 32'(busy_s[k]), 32'd1);
        wait_valid(k, cyc);
        check({nm, "_latency"}, 32'(cyc), 32'(steps + 1));
        if (lit_en) begin
            check({nm, "_result"}, 32'(res_s[k]), 32'(lr));
            check({nm, "_sat"}, 32'(sat_s[k]), 32'(ls));
        end
        if (do_ack) ack(k, nm);
    endtask

    // Every cycle an output is valid it must belong to a live job and match the model.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (valid_s[k]) begin
                    if (!pending[k]) begin
                        check($sformatf("cmp%0d_spurious_valid", k), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("cmp%0d_result", k), 32'(res_s[k]), 32'(exp_res[k]));
                        check($sformatf("cmp%0d_sat", k), 32'(sat_s[k]), 32'(exp_sat[k]));
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        logic [DW-1:0] nr;
        logic ns;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            ready_s[k] = 1'b0;
            pending[k] = 1'b0;
            exp_res[k] = '0;
            exp_sat[k] = 1'b0;
        end
        set_all(16'h0000, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset%0d_busy", k), 32'(busy_s[k]), 32'd0);
            check($sformatf("reset%0d_valid", k), 32'(valid_s[k]), 32'd0);
            check($sformatf("reset%0d_result", k), 32'(res_s[k]), 32'd0);
            check($sformatf("reset%0d_sat", k), 32'(sat_s[k]), 32'd0);
        end
        @(posedge clk); #1;

        // Basic accumulation, one lane and four lanes with a partial last step.
        set_all(16'h0100, 16'h0100, 16'h0000, 1'b0);
        run_job(0, 9, 1, 16'h0900, 1'b0, 1, "t1_l1");
        set_all(16'h0100, 16'h0100, 16'h0080, 1'b0);
        run_job(1, 3, 1, 16'h0980, 1'b0, 1, "t2_l4");

        // Rounding and sign.
        set_all(16'h0001, 16'h0080, 16'h0000, 1'b0);
        run_job(1, 3, 1, 16'h0005, 1'b0, 1, "t3_round_pos");
        set_all(16'h0001, 16'hFF80, 16'h0000, 1'b0);
        run_job(1, 3, 1, 16'hFFFC, 1'b0, 1, "t3_round_neg");
        set_all(16'h0001, 16'hFF80, 16'h0000, 1'b1);
        run_job(1, 3, 1, 16'h0000, 1'b0, 1, "t3_relu_nosat");

        // Saturation and ReLU.
        set_all(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0);
        run_job(0, 9, 1, 16'h7FFF, 1'b1, 1, "t4_sat_pos");
        set_all(16'h7FFF, 16'h8000, 16'h0000, 1'b0);
        run_job(0, 9, 1, 16'h8000, 1'b1, 1, "t4_sat_neg");
        set_all(16'h7FFF, 16'h8000, 16'h0000, 1'b1);
        run_job(0, 9, 1, 16'h0000, 1'b1, 1, "t4_sat_relu");

        // Mixed-sign directed windows, checked against the model.
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < NE; i++) begin
                img_a[i] = DW'(i * 37 - 100 + j * 300);
                flt_a[i] = DW'(50 - i * 23 - j * 61);
            end
            bias_v = DW'(j * 97 - 120);
            relu_v = j[0];
            run_job(1, 3, 0, 16'h0000, 1'b0, 1, "t_mixed");
        end

        // Backpressure: result held, start ignored, then back-to-back accept.
        set_all(16'h0200, 16'h0100, 16'h0000, 1'b0);
        run_job(1, 3, 1, 16'h1200, 1'b0, 0, "t5_first");
        for (int c = 0; c < 5; c++) begin
            start_s[1] = (c % 2 == 0);
            set_all(DW'(c * 11 + 3), DW'(c * 7 + 1), 16'h0010, 1'b0);
            @(posedge clk); #1;
            check("t5_valid_held", 32'(valid_s[1]), 32'd1);
            check("t5_result_held", 32'(res_s[1]), 32'h1200);
        end
        start_s[1] = 1'b0;
        set_all(16'h0100, 16'h0100, 16'h0080, 1'b0);
        model(nr, ns);
        ready_s[1] = 1'b1;
        start_s[1] = 1'b1;
        @(posedge clk); #1;
        ready_s[1] = 1'b0;
        start_s[1] = 1'b0;
        exp_res[1] = nr;
        exp_sat[1] = ns;
        scramble();
        check("t5_b2b_valid_drop", 32'(valid_s[1]), 32'd0);
        check("t5_b2b_busy", 32'(busy_s[1]), 32'd1);
        wait_valid(1, cyc);
        check("t5_b2b_latency", 32'(cyc), 32'd4);
        check("t5_b2b_result", 32'(res_s[1]), 32'h0980);
        ack(1, "t5_b2b");

        // Reset mid-RUN aborts the job with no output.
        set_all(16'h0100, 16'h0100, 16'h0000, 1'b0);
        model(nr, ns);
        exp_res[0] = nr;
        exp_sat[0] = ns;
        pending[0] = 1'b1;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_busy_reset", 32'(busy_s[0]), 32'd0);
        check("t6_valid_reset", 32'(valid_s[0]), 32'd0);
        pending[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("t6_no_output", 32'(valid_s[0]), 32'd0);
        check("t6_idle_busy", 32'(busy_s[0]), 32'd0);
        set_all(16'h0100, 16'h0100, 16'h0000, 1'b0);
        run_job(0, 9, 1, 16'h0900, 1'b0, 1, "t6_after");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
